// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the HI/LO pair.
// Shift-add multiply and restoring divide, one bit per clock.
module mult_div_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_d;
  logic              is_div_q, is_div_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic              dz_q, dz_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     work_q, work_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   hi_d, lo_d;
  logic              busy_d, done_d, dbz_d;

  logic              a_neg, b_neg;
  logic [XLEN:0]     msum;
  logic [XLEN:0]     rshift, rdiff;
  logic [PW-1:0]     mul_step, div_step, step, prod;
  logic [XLEN-1:0]   quot, rem;

  // One iteration of either algorithm; work holds {acc/rem, multiplier/quotient}
  always_comb begin
    a_neg    = op[0] & a[XLEN-1];
    b_neg    = op[0] & b[XLEN-1];
    msum     = {1'b0, work_q[PW-1:XLEN]} + (work_q[0] ? {1'b0, opb_q} : (XLEN+1)'(0));
    mul_step = {msum, work_q[XLEN-1:1]};
    rshift   = {work_q[PW-1:XLEN], work_q[XLEN-1]};
    rdiff    = rshift - {1'b0, opb_q};
    div_step = rdiff[XLEN] ? {rshift[XLEN-1:0], work_q[XLEN-2:0], 1'b0}
                           : {rdiff[XLEN-1:0],  work_q[XLEN-2:0], 1'b1};
    step     = is_div_q ? div_step : mul_step;
    prod     = (sign_a_q ^ sign_b_q) ? -step : step;
    quot     = step[XLEN-1:0];
    rem      = step[PW-1:XLEN];
  end

  // Next-state and register updates
  always_comb begin
    state_d  = state;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dz_d     = dz_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    opb_d    = opb_q;
    hi_d     = hi;
    lo_d     = lo;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    case (state)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          is_div_d = op[1];
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          dz_d     = op[1] & (b == '0);
          cnt_d    = '0;
          work_d   = {XLEN'(0), (a_neg ? -a : a)};
          opb_d    = b_neg ? -b : b;
          state_d  = RUN;
        end
      end
      RUN: begin
        work_d = step;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          dbz_d   = dz_q;
          // Divide by zero leaves HI/LO untouched
          if (!dz_q) begin
            if (is_div_q) begin
              lo_d = (sign_a_q ^ sign_b_q) ? -quot : quot;
              hi_d = sign_a_q ? -rem : rem;
            end else begin
              hi_d = prod[PW-1:XLEN];
              lo_d = prod[XLEN-1:0];
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      is_div_q    <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      dz_q        <= 1'b0;
      cnt_q       <= '0;
      work_q      <= '0;
      opb_q       <= '0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_d;
      is_div_q    <= is_div_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      dz_q        <= dz_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      opb_q       <= opb_d;
      hi          <= hi_d;
      lo          <= lo_d;
      busy        <= busy_d;
      done        <= done_d;
      div_by_zero <= dbz_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed table, corner sequences
// and random operations against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  mult_div_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    logic        exp_dz;
    int          inj;   // 0 none, 1 start re-pulse mid-run, 2 MTLO mid-run, 3 MTHI on start edge
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: MIPS semantics via plain 64-bit arithmetic
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] cur_hi, input logic [31:0] cur_lo,
                                output logic [31:0] nh, output logic [31:0] nl, output logic ndz);
    logic [63:0]        up;
    logic signed [63:0] sx, sy, sp, sq, sr;
    nh  = cur_hi;
    nl  = cur_lo;
    ndz = 1'b0;
    sx  = $signed({{32{x[31]}}, x});
    sy  = $signed({{32{y[31]}}, y});
    case (o)
      2'd0: begin up = {32'd0, x} * {32'd0, y}; nh = up[63:32]; nl = up[31:0]; end
      2'd1: begin sp = sx * sy; nh = sp[63:32]; nl = sp[31:0]; end
      2'd2: if (y == 0) ndz = 1'b1; else begin nl = x / y; nh = x % y; end
      default: if (y == 0) ndz = 1'b1;
               else begin sq = sx / sy; sr = sx % sy; nl = sq[31:0]; nh = sr[31:0]; end
    endcase
  endfunction

  task automatic mt(input logic sel_hi, input logic [31:0] d);
    @(negedge clk);
    hi_we = sel_hi;
    lo_we = ~sel_hi;
    wdata = d;
    @(posedge clk); #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int inj,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz, input string tag);
    int nbusy;
    int ndone;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    if (inj == 3) begin hi_we = 1'b1; wdata = 32'hDEAD_BEEF; end
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
    if (inj == 3) check({tag, ".mthi_with_start"}, 64'(hi), 64'h0000_0000_DEAD_BEEF);
    nbusy = busy ? 1 : 0;
    ndone = -1;
    for (int n = 1; n <= 40; n++) begin
      if (n == 5 && inj == 1) begin start = 1'b1; op = 2'd0; a = 32'h1234_5678; b = 32'h9; end
      if (n == 5 && inj == 2) begin lo_we = 1'b1; wdata = 32'h5; end
      @(posedge clk); #1;
      start = 1'b0; lo_we = 1'b0;
      if (busy) nbusy++;
      if (done) begin ndone = n; break; end
    end
    check({tag, ".done_latency"}, 64'(ndone), 64'd32);
    check({tag, ".busy_cycles"}, 64'(nbusy), 64'd33);
    check({tag, ".hi"}, 64'(hi), 64'(eh));
    check({tag, ".lo"}, 64'(lo), 64'(el));
    check({tag, ".div_by_zero"}, 64'(div_by_zero), 64'(edz));
    @(posedge clk); #1;
    check({tag, ".idle_after"}, {61'd0, busy, done, div_by_zero}, 64'd0);
  endtask

  initial begin
    logic [31:0] mh, ml, nh, nl, x, y;
    logic [1:0]  o;
    logic        ndz;
    int          ndone_cnt;

    vecs[0]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,  32'h0,  32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0};
    vecs[1]  = '{2'd1, 32'hFFFF_FFFD, 32'h7,         32'h0,  32'h0,  32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0};
    vecs[2]  = '{2'd3, 32'hFFFF_FFF9, 32'h2,         32'h0,  32'h0,  32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0};
    vecs[3]  = '{2'd2, 32'd100,       32'h0,         32'h11, 32'h22, 32'h11,        32'h22,        1'b1, 0};
    vecs[4]  = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,  32'h0,  32'h0,         32'h8000_0000, 1'b0, 2};
    vecs[5]  = '{2'd2, 32'd100,       32'd7,         32'h0,  32'h0,  32'h2,         32'hE,         1'b0, 1};
    vecs[6]  = '{2'd3, 32'd7,         32'hFFFF_FFFE, 32'h0,  32'h0,  32'h1,         32'hFFFF_FFFD, 1'b0, 0};
    vecs[7]  = '{2'd3, 32'd5,         32'h0,         32'hAA, 32'hBB, 32'hAA,        32'hBB,        1'b1, 0};
    vecs[8]  = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h0,  32'h0,  32'h4000_0000, 32'h0,         1'b0, 0};
    vecs[9]  = '{2'd0, 32'd3,         32'd5,         32'h0,  32'h0,  32'h0,         32'hF,         1'b0, 3};
    vecs[10] = '{2'd1, 32'hFFFF_FFFF, 32'h1,         32'h0,  32'h0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0};
    vecs[11] = '{2'd2, 32'hFFFF_FFFF, 32'h1,         32'h0,  32'h0,  32'h0,         32'hFFFF_FFFF, 1'b0, 0};
    vecs[12] = '{2'd0, 32'h1234_5678, 32'h0,         32'h7,  32'h9,  32'h0,         32'h0,         1'b0, 0};

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    check("reset.hilo", {hi, lo}, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      mt(1'b1, vecs[i].pre_hi);
      mt(1'b0, vecs[i].pre_lo);
      check($sformatf("vec%0d.preload", i), {hi, lo}, {vecs[i].pre_hi, vecs[i].pre_lo});
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].inj,
             vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dz, $sformatf("vec%0d", i));
    end

    // Random operations against the model
    mh = 32'hCAFE_0001;
    ml = 32'hCAFE_0002;
    mt(1'b1, mh);
    mt(1'b0, ml);
    for (int k = 0; k < 150; k++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) y = 32'd0;
      if ($urandom_range(0, 5) == 0) begin
        mh = $urandom;
        mt(1'b1, mh);
      end
      model(o, x, y, mh, ml, nh, nl, ndz);
      run_op(o, x, y, 0, nh, nl, ndz, $sformatf("rand%0d", k));
      mh = hi;
      ml = lo;
      mh = nh;
      ml = nl;
    end

    // Reset in the middle of a divide, with a re-pulsed start before it
    mt(1'b1, 32'h33);
    mt(1'b0, 32'h44);
    @(negedge clk);
    start = 1'b1; op = 2'd2; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      if (n == 5) begin start = 1'b1; op = 2'd1; a = $urandom; b = $urandom; end
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("midreset.busy_before", 64'(busy), 64'd1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("midreset.flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    check("midreset.hilo", {hi, lo}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    ndone_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done || busy) ndone_cnt++;
    end
    check("midreset.no_done", 64'(ndone_cnt), 64'd0);
    check("midreset.hilo_after", {hi, lo}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
